// File: rtl/svc_rv_dmem_bus_align.sv
// Retirement-aligned data-bus monitor: queues dmem transactions in MEM-stage order,
// captures BRAM read data after RD_LATENCY cycles, and replays each on rvfi_bus_* after retire.
module svc_rv_dmem_bus_align #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dmem_ren,
    input  logic [XLEN-1:0] dmem_raddr,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_we,
    input  logic [XLEN-1:0] dmem_waddr,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic [3:0]      dmem_wstrb,
    input  logic            rvfi_valid,
    input  logic [3:0]      rvfi_mem_rmask,
    input  logic [3:0]      rvfi_mem_wmask,
    output logic            rvfi_bus_valid,
    output logic            rvfi_bus_insn,
    output logic            rvfi_bus_data,
    output logic            rvfi_bus_fault,
    output logic [XLEN-1:0] rvfi_bus_addr,
    output logic [3:0]      rvfi_bus_rmask,
    output logic [3:0]      rvfi_bus_wmask,
    output logic [XLEN-1:0] rvfi_bus_rdata,
    output logic [XLEN-1:0] rvfi_bus_wdata,
    output logic            align_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic            r_is_wr [DEPTH];
    logic [XLEN-1:0] r_addr  [DEPTH];
    logic [XLEN-1:0] r_wdata [DEPTH];
    logic [XLEN-1:0] r_rdata [DEPTH];
    logic [3:0]      r_wstrb [DEPTH];
    logic            r_ready [DEPTH];
    logic [AW-1:0]   r_rptr;
    logic [AW-1:0]   r_wptr;
    logic [AW:0]     r_count;

    logic            r_pipe_vld [RD_LATENCY];
    logic [AW-1:0]   r_pipe_idx [RD_LATENCY];

    logic            r_bus_valid;
    logic [XLEN-1:0] r_bus_addr;
    logic [3:0]      r_bus_rmask;
    logic [3:0]      r_bus_wmask;
    logic [XLEN-1:0] r_bus_rdata;
    logic [XLEN-1:0] r_bus_wdata;
    logic            r_align_err;

    logic            w_full;
    logic            w_empty;
    logic            w_retire;
    logic            w_pop;
    logic            w_push;
    logic            w_push_ok;
    logic            w_fill_vld;
    logic [AW-1:0]   w_fill_idx;
    logic            w_fill_head;
    logic            w_head_wr;
    logic            w_head_ready;
    logic [XLEN-1:0] w_head_rdata;
    logic            w_mismatch;
    logic            w_err;
    logic [XLEN-1:0] w_raw_addr;
    logic [XLEN-1:0] w_push_addr;

    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_retire    = rvfi_valid & (|(rvfi_mem_rmask | rvfi_mem_wmask));
    assign w_pop       = w_retire & ~w_empty;
    assign w_push      = dmem_ren | dmem_we;
    assign w_push_ok   = w_push & (~w_full | w_pop);
    assign w_fill_vld  = r_pipe_vld[RD_LATENCY-1];
    assign w_fill_idx  = r_pipe_idx[RD_LATENCY-1];
    assign w_fill_head = w_fill_vld & (w_fill_idx == r_rptr);

    // A fill landing on the head in the pop cycle is forwarded straight to the output.
    assign w_head_wr    = r_is_wr[r_rptr];
    assign w_head_ready = r_ready[r_rptr] | w_fill_head;
    assign w_head_rdata = w_fill_head      ? dmem_rdata :
                          r_ready[r_rptr]  ? r_rdata[r_rptr] : '0;
    assign w_mismatch   = w_head_wr ? (rvfi_mem_wmask == 4'd0) : (rvfi_mem_rmask == 4'd0);

    assign w_err = (dmem_ren & dmem_we)
                 | (w_retire & w_empty)
                 | (w_pop & (~w_head_ready | w_mismatch))
                 | (w_push & w_full & ~w_pop);

    // Simultaneous read and write pushes the write only.
    assign w_raw_addr  = dmem_we ? dmem_waddr : dmem_raddr;
    assign w_push_addr = {w_raw_addr[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_is_wr[i] <= 1'b0;
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_rdata[i] <= '0;
                r_wstrb[i] <= '0;
                r_ready[i] <= 1'b0;
            end
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_fill_vld) begin
                r_rdata[w_fill_idx] <= dmem_rdata;
                r_ready[w_fill_idx] <= 1'b1;
            end
            // Push follows the fill so a slot reused in a full push+pop cycle takes the new entry.
            if (w_push_ok) begin
                r_is_wr[r_wptr] <= dmem_we;
                r_addr[r_wptr]  <= w_push_addr;
                r_wdata[r_wptr] <= dmem_wdata;
                r_wstrb[r_wptr] <= dmem_wstrb;
                r_rdata[r_wptr] <= '0;
                r_ready[r_wptr] <= dmem_we;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // In-flight fills for a popped entry are cancelled so a later reuse of the slot is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                r_pipe_vld[k] <= 1'b0;
                r_pipe_idx[k] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_push_ok & ~dmem_we;
            r_pipe_idx[0] <= r_wptr;
            for (int unsigned k = 1; k < RD_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1] & ~(w_pop & (r_pipe_idx[k-1] == r_rptr));
                r_pipe_idx[k] <= r_pipe_idx[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_valid <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_rmask <= '0;
            r_bus_wmask <= '0;
            r_bus_rdata <= '0;
            r_bus_wdata <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_bus_valid <= w_pop;
            r_bus_addr  <= w_pop ? r_addr[r_rptr] : '0;
            r_bus_wmask <= (w_pop & w_head_wr)  ? r_wstrb[r_rptr] : '0;
            r_bus_wdata <= (w_pop & w_head_wr)  ? r_wdata[r_rptr] : '0;
            r_bus_rmask <= (w_pop & ~w_head_wr) ? rvfi_mem_rmask  : '0;
            r_bus_rdata <= (w_pop & ~w_head_wr) ? w_head_rdata    : '0;
            r_align_err <= r_align_err | w_err;
        end
    end

    assign rvfi_bus_valid = r_bus_valid;
    assign rvfi_bus_insn  = 1'b0;
    assign rvfi_bus_data  = r_bus_valid;
    assign rvfi_bus_fault = 1'b0;
    assign rvfi_bus_addr  = r_bus_addr;
    assign rvfi_bus_rmask = r_bus_rmask;
    assign rvfi_bus_wmask = r_bus_wmask;
    assign rvfi_bus_rdata = r_bus_rdata;
    assign rvfi_bus_wdata = r_bus_wdata;
    assign align_err      = r_align_err;

endmodule

// File: tb/tb_svc_rv_dmem_bus_align.sv
// Bench for svc_rv_dmem_bus_align: RD_LATENCY=1 and =2 instances share stimulus and are
// checked every cycle against a transaction-queue reference model plus directed constants.
module tb_svc_rv_dmem_bus_align;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        dmem_ren, dmem_we, rvfi_valid;
    logic [31:0] dmem_raddr, dmem_rdata, dmem_waddr, dmem_wdata;
    logic [3:0]  dmem_wstrb, rvfi_mem_rmask, rvfi_mem_wmask;

    logic        bv [2];
    logic        bi [2];
    logic        bd [2];
    logic        bf [2];
    logic        ae [2];
    logic [31:0] ba [2];
    logic [31:0] brd [2];
    logic [31:0] bwd [2];
    logic [3:0]  brm [2];
    logic [3:0]  bwm [2];

    always #5 clk = ~clk;

    svc_rv_dmem_bus_align #(.XLEN(32), .DEPTH(DEPTH), .RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .rvfi_valid(rvfi_valid), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_bus_valid(bv[0]), .rvfi_bus_insn(bi[0]), .rvfi_bus_data(bd[0]), .rvfi_bus_fault(bf[0]),
        .rvfi_bus_addr(ba[0]), .rvfi_bus_rmask(brm[0]), .rvfi_bus_wmask(bwm[0]),
        .rvfi_bus_rdata(brd[0]), .rvfi_bus_wdata(bwd[0]), .align_err(ae[0])
    );

    svc_rv_dmem_bus_align #(.XLEN(32), .DEPTH(DEPTH), .RD_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .rvfi_valid(rvfi_valid), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_bus_valid(bv[1]), .rvfi_bus_insn(bi[1]), .rvfi_bus_data(bd[1]), .rvfi_bus_fault(bf[1]),
        .rvfi_bus_addr(ba[1]), .rvfi_bus_rmask(brm[1]), .rvfi_bus_wmask(bwm[1]),
        .rvfi_bus_rdata(brd[1]), .rvfi_bus_wdata(bwd[1]), .align_err(ae[1])
    );

    // Reference model: ordered list of issued transactions; read data is looked up from the
    // per-cycle history of dmem_rdata at (issue cycle + latency).
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } txn_t;

    txn_t        q[$];
    int          cyc;
    logic [31:0] hist [16384];
    logic        m_valid [2];
    logic        m_err [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_rd [2];
    logic [31:0] m_wd [2];
    logic [3:0]  m_rm [2];
    logic [3:0]  m_wm [2];

    int tests = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_err[i] = 0; m_addr[i] = '0; m_rd[i] = '0;
            m_wd[i] = '0; m_rm[i] = '0; m_wm[i] = '0;
        end
    endtask

    task automatic model_step();
        bit   retire, push;
        txn_t h, n;
        int   lat;
        hist[cyc] = dmem_rdata;
        retire = rvfi_valid && ((rvfi_mem_rmask | rvfi_mem_wmask) != 4'd0);
        push   = dmem_ren || dmem_we;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_addr[i] = '0; m_rd[i] = '0; m_wd[i] = '0; m_rm[i] = '0; m_wm[i] = '0;
            if (dmem_ren && dmem_we) m_err[i] = 1;
        end
        if (retire) begin
            if (q.size() == 0) begin
                m_err[0] = 1; m_err[1] = 1;
            end else begin
                h = q.pop_front();
                for (int i = 0; i < 2; i++) begin
                    lat = i + 1;
                    m_valid[i] = 1;
                    m_addr[i]  = h.addr;
                    if (h.wr) begin
                        m_wm[i] = h.wstrb;
                        m_wd[i] = h.wdata;
                        if (rvfi_mem_wmask == 4'd0) m_err[i] = 1;
                    end else begin
                        m_rm[i] = rvfi_mem_rmask;
                        if (cyc >= h.cyc + lat) m_rd[i] = hist[h.cyc + lat];
                        else m_err[i] = 1;
                        if (rvfi_mem_rmask == 4'd0) m_err[i] = 1;
                    end
                end
            end
        end
        if (push) begin
            if (q.size() == DEPTH) begin
                m_err[0] = 1; m_err[1] = 1;
            end else begin
                n.wr    = dmem_we;
                n.addr  = (dmem_we ? dmem_waddr : dmem_raddr) & 32'hFFFF_FFFC;
                n.wdata = dmem_wdata;
                n.wstrb = dmem_wstrb;
                n.cyc   = cyc;
                q.push_back(n);
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("L%0d valid", i+1), 32'(bv[i]), 32'(m_valid[i]));
            chk($sformatf("L%0d data",  i+1), 32'(bd[i]), 32'(m_valid[i]));
            chk($sformatf("L%0d insn",  i+1), 32'(bi[i]), 32'd0);
            chk($sformatf("L%0d fault", i+1), 32'(bf[i]), 32'd0);
            chk($sformatf("L%0d addr",  i+1), ba[i], m_addr[i]);
            chk($sformatf("L%0d rmask", i+1), 32'(brm[i]), 32'(m_rm[i]));
            chk($sformatf("L%0d wmask", i+1), 32'(bwm[i]), 32'(m_wm[i]));
            chk($sformatf("L%0d rdata", i+1), brd[i], m_rd[i]);
            chk($sformatf("L%0d wdata", i+1), bwd[i], m_wd[i]);
            chk($sformatf("L%0d err",   i+1), 32'(ae[i]), 32'(m_err[i]));
        end
    endtask

    task automatic set_idle();
        dmem_ren = 0; dmem_raddr = '0; dmem_rdata = $urandom;
        dmem_we = 0; dmem_waddr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        rvfi_valid = 0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
    endtask

    // Inputs for the current cycle are already driven; sample outputs #1 after the edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        set_idle();
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("L%0d rst valid", i+1), 32'(bv[i]), 32'd0);
            chk($sformatf("L%0d rst addr",  i+1), ba[i], 32'd0);
            chk($sformatf("L%0d rst rdata", i+1), brd[i], 32'd0);
            chk($sformatf("L%0d rst wdata", i+1), bwd[i], 32'd0);
            chk($sformatf("L%0d rst masks", i+1), {24'd0, brm[i], bwm[i]}, 32'd0);
            chk($sformatf("L%0d rst err",   i+1), 32'(ae[i]), 32'd0);
        end
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dmem_we = 1; dmem_waddr = a; dmem_wdata = d; dmem_wstrb = s;
    endtask

    task automatic rd(input logic [31:0] a);
        dmem_ren = 1; dmem_raddr = a;
    endtask

    task automatic ret(input logic [3:0] rm, input logic [3:0] wm);
        rvfi_valid = 1; rvfi_mem_rmask = rm; rvfi_mem_wmask = wm;
    endtask

    initial begin
        bit r;
        cyc = 0;
        set_idle();
        model_clear();
        #1;
        do_reset();
        set_idle();
        step();

        // Write replay
        wr(32'h103, 32'hDEADBEEF, 4'b1000); step();
        step();
        ret(4'b0000, 4'b1000); step();
        chk("wr valid", 32'(bv[0]), 32'd1);
        chk("wr addr",  ba[0], 32'h100);
        chk("wr wmask", 32'(bwm[0]), 32'h8);
        chk("wr wdata", bwd[0], 32'hDEADBEEF);
        chk("wr rmask", 32'(brm[0]), 32'd0);
        chk("wr err",   32'(ae[0]), 32'd0);

        // Read replay; the latency-2 instance sees the retire in its fill cycle
        rd(32'h204); step();
        dmem_rdata = 32'h12345678; step();
        dmem_rdata = 32'h0BADF00D; ret(4'b1111, 4'b0000); step();
        chk("rd L1 rdata", brd[0], 32'h12345678);
        chk("rd L1 addr",  ba[0], 32'h204);
        chk("rd L1 wmask", 32'(bwm[0]), 32'd0);
        chk("rd L2 rdata", brd[1], 32'h0BADF00D);
        chk("rd L2 err",   32'(ae[1]), 32'd0);

        // Full and wrap
        for (int k = 0; k < 4; k++) begin
            wr(32'h1000 + 32'(4*k), 32'hA000_0000 + 32'(k), 4'hF); step();
        end
        for (int k = 4; k < 14; k++) begin
            wr(32'h1000 + 32'(4*k), 32'hA000_0000 + 32'(k), 4'hF); ret(4'b0000, 4'hF); step();
            chk("wrap order", ba[0], 32'h1000 + 32'(4*(k-4)));
        end
        chk("wrap no err", 32'(ae[0]), 32'd0);
        wr(32'h2000, 32'h1, 4'hF); step();
        chk("overflow err L1", 32'(ae[0]), 32'd1);
        chk("overflow err L2", 32'(ae[1]), 32'd1);

        // Retire on empty FIFO
        do_reset(); step();
        ret(4'b0001, 4'b0000); step();
        chk("empty no pulse", 32'(bv[0]), 32'd0);
        chk("empty err", 32'(ae[0]), 32'd1);
        step(); step(); step();
        chk("empty err sticky", 32'(ae[0]), 32'd1);

        // Read and write together: write pushed, error flagged
        do_reset(); step();
        rd(32'h40); wr(32'h83, 32'h55, 4'b0011); step();
        chk("both err", 32'(ae[0]), 32'd1);
        ret(4'b0000, 4'b0011); step();
        chk("both addr", ba[0], 32'h80);
        chk("both wmask", 32'(bwm[0]), 32'h3);

        // Type mismatch: write entry retired with only a read mask
        do_reset(); step();
        wr(32'h300, 32'h77, 4'b0110); step();
        ret(4'b1111, 4'b0000); step();
        chk("mismatch err", 32'(ae[0]), 32'd1);
        chk("mismatch wmask", 32'(bwm[0]), 32'h6);

        // Reset mid-operation with entries queued and a fill in flight
        do_reset(); step();
        wr(32'h400, 32'h1, 4'hF); step();
        wr(32'h404, 32'h2, 4'hF); step();
        wr(32'h408, 32'h3, 4'hF); step();
        rd(32'h500); ret(4'b0000, 4'hF); step();
        chk("pre-reset pulse", 32'(bv[0]), 32'd1);
        do_reset();
        wr(32'h600, 32'hCAFEF00D, 4'hF); step();
        ret(4'b0000, 4'hF); step();
        chk("post-reset addr", ba[0], 32'h600);
        chk("post-reset wdata", bwd[0], 32'hCAFEF00D);
        step(); step();

        // Legal random traffic: no error may ever be flagged
        do_reset(); step();
        for (int n = 0; n < 1500; n++) begin
            r = (q.size() > 0) && (q[0].wr || cyc >= q[0].cyc + 2) && ($urandom % 2 == 0);
            if (r) begin
                if (q[0].wr) ret(4'b0000, 4'($urandom_range(1, 15)));
                else         ret(4'($urandom_range(1, 15)), 4'b0000);
            end else if ($urandom % 4 == 0) begin
                ret(4'b0000, 4'b0000);
            end
            if ((q.size() < DEPTH || r) && ($urandom % 3 != 0)) begin
                if ($urandom % 2 == 0) wr($urandom, $urandom, 4'($urandom_range(1, 15)));
                else                   rd($urandom);
            end
            step();
        end
        chk("legal L1 err", 32'(ae[0]), 32'd0);
        chk("legal L2 err", 32'(ae[1]), 32'd0);

        // Unconstrained random traffic
        do_reset(); step();
        for (int n = 0; n < 1000; n++) begin
            dmem_ren = ($urandom % 3 == 0); dmem_raddr = $urandom;
            dmem_we  = ($urandom % 3 == 0); dmem_waddr = $urandom;
            dmem_wdata = $urandom; dmem_wstrb = 4'($urandom);
            rvfi_valid = ($urandom % 2 == 0);
            rvfi_mem_rmask = ($urandom % 2 == 0) ? 4'($urandom) : 4'd0;
            rvfi_mem_wmask = ($urandom % 2 == 0) ? 4'($urandom) : 4'd0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/svc_rv_dmem_bus_align.md
# svc_rv_dmem_bus_align

Retirement-aligned data-bus monitor for the svc_rv core: records every raw data-memory transaction in the order the core issues it in the MEM stage, and captures BRAM read data when it arrives `RD_LATENCY` cycles later. It replays each transaction on an RVFI_BUS-style output port in the cycle after the owning instruction retires on RVFI (WB stage). It sits between the core's dmem port / RVFI outputs and the riscv-formal `rvfi_bus_*` checker inputs, resolving the MEM-vs-WB and BRAM-latency skew.

## Interface
Parameters:
- `XLEN`, 32: data and address width.
- `DEPTH`, 4: transaction FIFO entries; power of two, at least 2.
- `RD_LATENCY`, 1: cycles from `dmem_ren` to valid `dmem_rdata`; legal values are 1 or 2.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `dmem_ren` in 1: read issue.
- `dmem_raddr` in XLEN: read byte address.
- `dmem_rdata` in XLEN: read data, valid `RD_LATENCY` cycles after the `dmem_ren` cycle.
- `dmem_we` in 1: write issue.
- `dmem_waddr` in XLEN: write byte address.
- `dmem_wdata` in XLEN: write data.
- `dmem_wstrb` in 4: write byte strobes.
- `rvfi_valid` in 1: instruction retired.
- `rvfi_mem_rmask` in 4: retired instruction's read mask.
- `rvfi_mem_wmask` in 4: retired instruction's write mask.
- `rvfi_bus_valid` out 1: replayed transaction valid, one-cycle pulse.
- `rvfi_bus_insn` out 1: constant 0.
- `rvfi_bus_data` out 1: equals `rvfi_bus_valid`.
- `rvfi_bus_fault` out 1: constant 0.
- `rvfi_bus_addr` out XLEN: word-aligned address (bits 1:0 are 0).
- `rvfi_bus_rmask` out 4: read mask.
- `rvfi_bus_wmask` out 4: write mask.
- `rvfi_bus_rdata` out XLEN: read data.
- `rvfi_bus_wdata` out XLEN: write data.
- `align_err` out 1: sticky alignment error flag.

## Operation
- **Push.** When `dmem_ren` or `dmem_we` is asserted, push an entry {is_wr, addr & ~3, wdata, wstrb, rdata=0, ready}.
  - A write sets ready=1 immediately.
  - A read sets ready=0.
  - If `dmem_ren` and `dmem_we` are both asserted: push the write only and set `align_err`.
- **Read fill.** A read push loads its entry index into a `RD_LATENCY`-deep tracking pipe. When the index emerges, write `dmem_rdata` into that entry and set ready=1. A fill whose entry has already been popped is dropped.
- **Retire.** `rvfi_valid` with `rvfi_mem_rmask | rvfi_mem_wmask` nonzero is a memory retire.
  - On a memory retire, pop the head entry.
  - Register the outputs: addr, and wdata/wstrb as `rvfi_bus_wmask` for writes (rmask 0).
  - For reads, output rdata and `rvfi_mem_rmask` as `rvfi_bus_rmask` (wmask 0).
  - A retire with no memory masks does not pop.
- **Errors.** Each of these sets `align_err`, which stays set until reset:
  - Retire on an empty FIFO: no output pulse.
  - Head entry not ready: pop anyway and emit rdata=0.
  - Head entry type mismatch: write entry with wmask=0, or read entry with rmask=0. Emit the entry as stored.
  - Push while full with no same-cycle pop: the push is dropped.
- **Simultaneous push and pop.**
  - When full, a simultaneous push and pop is legal and the count is unchanged.
  - When empty, a simultaneous push and pop is a retire on an empty FIFO: error.
  - A fill and a pop of the same entry in the same cycle are legal. The popped output uses the `dmem_rdata` forwarded that cycle, and no error is raised.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Reset state: every output 0 and the FIFO empty, pointers 0, tracking pipe cleared, `align_err` 0.
  - Reset asserted mid-operation discards all entries and in-flight fills immediately (asynchronous).
- Push to fill: `RD_LATENCY` cycles.
- Retire to `rvfi_bus_valid`: exactly 1 cycle, registered.
  - `rvfi_bus_valid` is high for one cycle per memory retire.
  - Back-to-back retires produce back-to-back pulses.
- No backpressure. Inputs are sampled every cycle; the core never stalls on this block.
- Address: `addr & ~3` is computed at push time.

## Test plan
- **Write replay.** Push a write to 0x103 with wdata 0xDEADBEEF and wstrb 0b1000; retire 2 cycles later with wmask 0b1000 -> next cycle valid=1, addr 0x100, wmask 0b1000, wdata 0xDEADBEEF, rmask 0, no error.
- **Read replay.** Read 0x204, `RD_LATENCY`=1, rdata 0x12345678 on the following cycle; retire 2 cycles after the issue with rmask 0b1111 -> valid pulse, addr 0x204, rdata 0x12345678, wmask 0.
- **Same-cycle fill and pop.** `RD_LATENCY`=2: retire in the same cycle the data arrives -> output rdata equals that cycle's `dmem_rdata`, `align_err` stays 0.
- **Full and wrap.** `DEPTH`=4: issue 4 ops, then push and retire in the same cycle repeatedly for 10 cycles -> no error, outputs in issue order, pointers wrap. One more push while full with no pop -> `align_err`=1.
- **Error cases.** Memory retire on an empty FIFO -> no valid pulse, `align_err`=1, sticky. `dmem_ren` and `dmem_we` asserted together -> `align_err`=1.
- **Reset mid-operation.** Assert `rst_n`=0 with 3 entries queued and a fill in flight -> all outputs 0 immediately. After release, a fresh write and retire replays correctly with no stale data.
